rgb_sequence_monitor: RTL



---
 rtl/rgb_sequence_monitor_if.sv | 29 ++
 rtl/rgb_sequence_monitor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rgb_sequence_monitor_if.sv
// Signal bundle between an RGB LED driver (master) and the sequence monitor (slave).
// The monitor sees the three LED lines and drives back the lock, pulse and statistics outputs.
interface rgb_sequence_monitor_if #(
  parameter int CNT_W = 21
);
  logic             red;
  logic             green;
  logic             blue;
  logic             color_valid;
  logic [2:0]       color_code;
  logic             locked;
  logic             step_pulse;
  logic             seq_error;
  logic             timing_error;
  logic [CNT_W-1:0] dwell_cycles;
  logic [7:0]       error_count;

  modport master (
    output red, green, blue,
    input  color_valid, color_code, locked, step_pulse,
    input  seq_error, timing_error, dwell_cycles, error_count
  );

  modport slave (
    input  red, green, blue,
    output color_valid, color_code, locked, step_pulse,
    output seq_error, timing_error, dwell_cycles, error_count
  );
endinterface

// File: rtl/rgb_sequence_monitor.sv
// Receive-side checker for the six-colour RGB LED cycle: decodes colours, locks onto
// the RED->YELLOW->GREEN->CYAN->BLUE->MAGENTA order and flags order/dwell violations.
module rgb_sequence_monitor #(
  parameter int BLINK_INTERVAL = 2000000,
  parameter int TOLERANCE      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_sequence_monitor_if.slave mon
);
  localparam int CNT_W = $clog2(BLINK_INTERVAL + TOLERANCE + 2);
  localparam int MAX   = BLINK_INTERVAL + TOLERANCE + 1;
  localparam int LO    = BLINK_INTERVAL - TOLERANCE;
  localparam int HI    = BLINK_INTERVAL + TOLERANCE;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  // Returns {valid, index}; invalid codes map to index 0.
  function automatic logic [3:0] decode(input logic [2:0] rgb);
    case (rgb)
      3'b100:  return {1'b1, 3'd0};
      3'b110:  return {1'b1, 3'd1};
      3'b010:  return {1'b1, 3'd2};
      3'b011:  return {1'b1, 3'd3};
      3'b001:  return {1'b1, 3'd4};
      3'b101:  return {1'b1, 3'd5};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(MAX)) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_err(input logic [7:0] e);
    return (e == 8'd255) ? e : e + 8'd1;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       samp_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, locked_q, step_q, seq_q, tim_q;
  logic [2:0]       code_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [7:0]       err_q, err_d;
  logic             step_d, seq_d, tim_d;

  logic             change, succ_ok, dwell_ok, at_max;
  logic             new_v, old_v;
  logic [2:0]       new_i, old_i;

  assign {new_v, new_i} = decode(samp_q);
  assign {old_v, old_i} = decode(prev_q);
  assign change   = (samp_q != prev_q);
  assign succ_ok  = new_v && old_v && (new_i == next_idx(old_i));
  assign dwell_ok = (cnt_q >= CNT_W'(LO)) && (cnt_q <= CNT_W'(HI));
  assign at_max   = (cnt_q == CNT_W'(MAX));

  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    seq_d   = 1'b0;
    tim_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (change && succ_ok) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (change) begin
          if (succ_ok && dwell_ok) begin
            state_d = LOCKED;
            step_d  = 1'b1;
          end else if (!succ_ok) begin
            state_d = SEARCH;
          end
        end else if (at_max) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (change) begin
          if (succ_ok && dwell_ok) begin
            step_d = 1'b1;
          end else begin
            seq_d   = !succ_ok;
            tim_d   = !dwell_ok;
            state_d = SEARCH;
          end
        end else if (at_max) begin
          // Colour stuck: report once, then stop judging until re-acquired.
          tim_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    cnt_d   = change ? CNT_W'(1) : sat_cnt(cnt_q);
    dwell_d = change ? cnt_q : dwell_q;
    err_d   = (seq_d || tim_d) ? sat_err(err_q) : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q   <= 3'b000;
      prev_q   <= 3'b000;
      cnt_q    <= '0;
      state_q  <= SEARCH;
      valid_q  <= 1'b0;
      code_q   <= 3'd0;
      locked_q <= 1'b0;
      step_q   <= 1'b0;
      seq_q    <= 1'b0;
      tim_q    <= 1'b0;
      dwell_q  <= '0;
      err_q    <= 8'd0;
    end else begin
      samp_q   <= {mon.red, mon.green, mon.blue};
      prev_q   <= samp_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      valid_q  <= new_v;
      code_q   <= new_i;
      locked_q <= (state_d == LOCKED);
      step_q   <= step_d;
      seq_q    <= seq_d;
      tim_q    <= tim_d;
      dwell_q  <= dwell_d;
      err_q    <= err_d;
    end
  end

  assign mon.color_valid  = valid_q;
  assign mon.color_code   = code_q;
  assign mon.locked       = locked_q;
  assign mon.step_pulse   = step_q;
  assign mon.seq_error    = seq_q;
  assign mon.timing_error = tim_q;
  assign mon.dwell_cycles = dwell_q;
  assign mon.error_count  = err_q;
endmodule
